// File: rtl/d7s_seq.sv
// Serial binary-to-BCD converter (double dabble, one bit per clock) driving
// active-low seven-segment digits with sign, leading-zero blanking and overflow.
module d7s_seq #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SIGNED   = 0,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic [6:0]            seg_sign,
  output logic [1:0]            dbg_state
);

  // Handshake: start is a request taken only while busy=0 (IDLE); it is
  // acknowledged implicitly by busy rising on the next cycle. Requests seen
  // while busy=1 are dropped. done is a one-cycle result-valid strobe.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] acc_q, acc_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d, ovf_q, ovf_d, nz_q, nz_d;
  logic [WIDTH-1:0]    mag;
  logic                neg_in, ovf_in;
  logic [7*DIGITS-1:0] seg_next;
  logic                lead;
  logic [3:0]          nib;

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Magnitude of the incoming value; the most negative input wraps to 2^(WIDTH-1).
  always_comb begin
    neg_in = 1'b0;
    mag    = in_data;
    if (SIGNED != 0 && in_data[WIDTH-1]) begin
      neg_in = 1'b1;
      mag    = -in_data;
    end
    ovf_in = {{(64-WIDTH){1'b0}}, mag} > MAX_VAL;
  end

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    nz_d    = nz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = mag;
          neg_d   = neg_in;
          ovf_d   = ovf_in;
          nz_d    = |mag;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = CONV;
        end
      end
      CONV: begin
        // The top accumulator bit falls off here, so overflowed values keep
        // only their low DIGITS decimal digits.
        {acc_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      nz_q    <= nz_d;
    end
  end

  // Scan from the most significant digit; lead stays set while only zeros seen.
  always_comb begin
    seg_next = '1;
    lead     = 1'b1;
    nib      = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = acc_q[4*i +: 4];
      if (nib != 4'd0) lead = 1'b0;
      if (ovf_q)                              seg_next[7*i +: 7] = SEG_DASH;
      else if (BLANK_LZ != 0 && i > 0 && lead) seg_next[7*i +: 7] = SEG_BLANK;
      else                                    seg_next[7*i +: 7] = seg_code(nib);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      seg      <= '1;
      seg_sign <= SEG_BLANK;
    end else begin
      done <= (state_q == UPDATE);
      if (state_q == UPDATE) begin
        bcd      <= acc_q;
        seg      <= seg_next;
        seg_sign <= (neg_q && nz_q) ? SEG_DASH : SEG_BLANK;
        overflow <= ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_d7s_seq.sv
// Bench for d7s_seq: three instances (default, signed, two-digit) share one
// stimulus stream; an arithmetic reference model feeds per-instance queues.
module tb_d7s_seq;

  localparam int W = 41;  // {overflow, seg_sign, seg[20:0], bcd[11:0]}
  localparam int LAT = 10;
  localparam logic [6:0] BLK  = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [W-1:0] RST_VEC = {1'b0, BLK, {21{1'b1}}, 12'h000};

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic reset, start;
  logic [7:0] in_data;
  always #5 clk = ~clk;

  logic busy_a, done_a, ovf_a; logic [11:0] bcd_a; logic [20:0] seg_a; logic [6:0] sign_a; logic [1:0] dbg_a;
  logic busy_b, done_b, ovf_b; logic [11:0] bcd_b; logic [20:0] seg_b; logic [6:0] sign_b; logic [1:0] dbg_b;
  logic busy_c, done_c, ovf_c; logic [7:0]  bcd_c; logic [13:0] seg_c; logic [6:0] sign_c; logic [1:0] dbg_c;

  d7s_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .BLANK_LZ(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .bcd(bcd_a), .seg(seg_a), .seg_sign(sign_a), .dbg_state(dbg_a));
  d7s_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .bcd(bcd_b), .seg(seg_b), .seg_sign(sign_b), .dbg_state(dbg_b));
  d7s_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0), .BLANK_LZ(1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .busy(busy_c), .done(done_c),
    .overflow(ovf_c), .bcd(bcd_c), .seg(seg_c), .seg_sign(sign_c), .dbg_state(dbg_c));

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_a_q[$], exp_b_q[$], exp_c_q[$];
  int exp_t_q[$];
  int cyc = 0, free_edge = 0, last_a = -100, acc_cnt = 0;
  bit active = 1'b0;
  logic [W-1:0] cur_a = RST_VEC;
  int n_pass = 0, n_total = 0;
  bit exp_done_a, busy_exp_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return BLK;
    endcase
  endfunction

  // Decimal arithmetic on the integer value: digits by division, blanking by
  // comparing the value against powers of ten.
  function automatic logic [W-1:0] ref_model(input logic [7:0] v, input int digits, input bit sgn);
    int mag, p, d;
    bit neg, ovf;
    logic [20:0] s;
    logic [11:0] b;
    logic [6:0] sg;
    neg = sgn && v[7];
    mag = neg ? 256 - int'(v) : int'(v);
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    ovf = (mag >= p);
    s = '0;
    b = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      d = (mag / p) % 10;
      b[4*i +: 4] = 4'(d);
      if (ovf)                s[7*i +: 7] = DASH;
      else if (i > 0 && mag < p) s[7*i +: 7] = BLK;
      else                    s[7*i +: 7] = seg_of(d);
      p = p * 10;
    end
    sg = (neg && mag != 0) ? DASH : BLK;
    return {ovf, sg, s, b};
  endfunction

  // Acceptance model: a start is taken on any edge at or after free_edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset && start && cyc >= free_edge) begin
      exp_a_q.push_back(ref_model(in_data, 3, 1'b0));
      exp_b_q.push_back(ref_model(in_data, 3, 1'b1));
      exp_c_q.push_back(ref_model(in_data, 2, 1'b0));
      exp_t_q.push_back(cyc + LAT - 1);
      last_a    = cyc;
      free_edge = cyc + LAT;
      active    = 1'b1;
      acc_cnt++;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    #2;
    exp_done_a = (exp_t_q.size() > 0) && (exp_t_q[0] == cyc);
    check("done_a", done_a, exp_done_a);
    if (exp_done_a) void'(exp_t_q.pop_front());
    if (done_a && exp_a_q.size() > 0) cur_a = exp_a_q.pop_front();
    check("outputs_a", {ovf_a, sign_a, seg_a, bcd_a}, cur_a);
    busy_exp_a = active && (cyc >= last_a) && (cyc <= last_a + LAT - 2);
    check("busy_a", busy_a, busy_exp_a);
  end

  always @(negedge clk) begin
    #2;
    if (done_b) begin
      if (exp_b_q.size() == 0) check("done_b_unexpected", done_b, 1'b0);
      else check("result_b", {ovf_b, sign_b, seg_b, bcd_b}, exp_b_q.pop_front());
    end
    if (done_c) begin
      if (exp_c_q.size() == 0) check("done_c_unexpected", done_c, 1'b0);
      else check("result_c", {ovf_c, sign_c, 7'b0, seg_c, 4'b0, bcd_c}, exp_c_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] v, input bit poke);
    int guard = 0;
    @(negedge clk);
    while (cyc + 1 < free_edge && guard < 100) begin
      if (poke && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        in_data = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    in_data = v;
    @(negedge clk);
    start = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic apply_reset_checks(input string tag);
    reset = 1'b1;
    exp_a_q.delete(); exp_b_q.delete(); exp_c_q.delete(); exp_t_q.delete();
    active = 1'b0;
    free_edge = 0;
    cur_a = RST_VEC;
    #1;
    check({tag, "_bcd"}, bcd_a, 12'h000);
    check({tag, "_seg"}, seg_a, {21{1'b1}});
    check({tag, "_sign"}, sign_a, BLK);
    check({tag, "_ovf"}, ovf_a, 1'b0);
    check({tag, "_busy"}, busy_a, 1'b0);
    check({tag, "_done"}, done_a, 1'b0);
    check({tag, "_out_b"}, {ovf_b, sign_b, seg_b, bcd_b}, RST_VEC);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic back_to_back();
    int base, guard;
    guard = 0;
    @(negedge clk);
    while (cyc + 1 < free_edge) @(negedge clk);
    base = acc_cnt;
    start = 1'b1;
    in_data = 8'd10;
    @(negedge clk);
    in_data = 8'd20;
    while (acc_cnt < base + 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] directed[12];
    start = 1'b0;
    in_data = 8'h00;
    reset = 1'b1;
    @(negedge clk);
    apply_reset_checks("por");

    directed = '{8'd255, 8'd7, 8'd0, 8'h80, 8'hFF, 8'd99, 8'd100, 8'd250,
                 8'h9C, 8'd1, 8'd10, 8'd128};
    foreach (directed[i]) send(directed[i], 1'b0);

    // abort mid-conversion
    send(8'd200, 1'b0);
    repeat (3) @(negedge clk);
    apply_reset_checks("abort");
    send(8'd42, 1'b0);

    back_to_back();
    send(8'd77, 1'b1);

    repeat (40) send(8'($urandom), 1'($urandom_range(0, 1)));

    repeat (LAT + 5) @(negedge clk);
    check("drain_a", exp_a_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);
    check("drain_c", exp_c_q.size(), 0);
    check("drain_t", exp_t_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
